// File: rtl/mem_stage_c_if.sv
// EX -> MEM -> WB bundle for mem_stage_c.
// master drives EX results, slave is the MEM stage.
interface mem_stage_c_if;
   logic        iSAD;
   logic        iRegWriteCtrl;
   logic        iMove;
   logic        iMemRead;
   logic        iZero;
   logic        iHiLoWrite;
   logic [1:0]  iSEMux;
   logic [1:0]  iMemWrite;
   logic [2:0]  iMemToReg;
   logic [31:0] iPCPlus4;
   logic [31:0] iALUResult;
   logic [31:0] iReadReg1;
   logic [31:0] iReadReg2;
   logic [31:0] iHi;
   logic [31:0] iLo;
   logic [63:0] iHiLoResult;
   logic [4:0]  iRegDstResult;

   logic [4:0]  MEMrd;
   logic        MEMRegWrite;
   logic [31:0] MEMForwardData;

   logic        oRegWriteCtrl;
   logic        oSAD;
   logic        oMove;
   logic        oHiLoWrite;
   logic [2:0]  oMemToReg;
   logic [31:0] oMemReadData;
   logic [31:0] oALUResult;
   logic [31:0] oPCPlus4;
   logic [31:0] oHi;
   logic [31:0] oLo;
   logic [63:0] oHiLoResult;
   logic [4:0]  oRegDstResult;

   modport master (
      output iSAD, iRegWriteCtrl, iMove, iMemRead, iZero, iHiLoWrite,
      output iSEMux, iMemWrite, iMemToReg,
      output iPCPlus4, iALUResult, iReadReg1, iReadReg2, iHi, iLo,
      output iHiLoResult, iRegDstResult,
      input  MEMrd, MEMRegWrite, MEMForwardData,
      input  oRegWriteCtrl, oSAD, oMove, oHiLoWrite, oMemToReg,
      input  oMemReadData, oALUResult, oPCPlus4, oHi, oLo,
      input  oHiLoResult, oRegDstResult
   );

   modport slave (
      input  iSAD, iRegWriteCtrl, iMove, iMemRead, iZero, iHiLoWrite,
      input  iSEMux, iMemWrite, iMemToReg,
      input  iPCPlus4, iALUResult, iReadReg1, iReadReg2, iHi, iLo,
      input  iHiLoResult, iRegDstResult,
      output MEMrd, MEMRegWrite, MEMForwardData,
      output oRegWriteCtrl, oSAD, oMove, oHiLoWrite, oMemToReg,
      output oMemReadData, oALUResult, oPCPlus4, oHi, oLo,
      output oHiLoResult, oRegDstResult
   );
endinterface

// File: rtl/mem_stage_c.sv
// MEM stage: EX/MEM register, byte-addressable data memory,
// MEM/WB register, and MEM-stage forwarding taps.
module mem_stage_c #(
   parameter int ADDR_W    = 10,
   parameter     INIT_FILE = ""
) (
   input  logic   Clk,
   input  logic   Reset,
   mem_stage_c_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef struct packed {
      logic        sad;
      logic        rw;
      logic        move;
      logic        mr;
      logic        hlw;
      logic [1:0]  semux;
      logic [1:0]  mw;
      logic [2:0]  m2r;
      logic [31:0] pc4;
      logic [31:0] alu;
      logic [31:0] rr2;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] hilo;
      logic [4:0]  rd;
   } ex_mem_t;

   typedef struct packed {
      logic        rw;
      logic        sad;
      logic        move;
      logic        hlw;
      logic [2:0]  m2r;
      logic [31:0] rdata;
      logic [31:0] alu;
      logic [31:0] pc4;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [63:0] hilo;
      logic [4:0]  rd;
   } mem_wb_t;

   ex_mem_t            r_em;
   mem_wb_t            r_wb;
   logic [31:0]        r_mem [DEPTH];

   logic [ADDR_W-1:0]  w_idx;
   logic [31:0]        w_word;
   logic [15:0]        w_half;
   logic [7:0]         w_byte;
   logic [31:0]        w_ext;
   logic [31:0]        w_rdata;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic               w_unused;

   // Zero flag and rs value are not needed past EX.
   assign w_unused = ^{bus.iZero, bus.iReadReg1};

   // EX/MEM register; a bubble arrives as all-zero controls.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_em <= '0;
      end else begin
         r_em.sad   <= bus.iSAD;
         r_em.rw    <= bus.iRegWriteCtrl;
         r_em.move  <= bus.iMove;
         r_em.mr    <= bus.iMemRead;
         r_em.hlw   <= bus.iHiLoWrite;
         r_em.semux <= bus.iSEMux;
         r_em.mw    <= bus.iMemWrite;
         r_em.m2r   <= bus.iMemToReg;
         r_em.pc4   <= bus.iPCPlus4;
         r_em.alu   <= bus.iALUResult;
         r_em.rr2   <= bus.iReadReg2;
         r_em.hi    <= bus.iHi;
         r_em.lo    <= bus.iLo;
         r_em.hilo  <= bus.iHiLoResult;
         r_em.rd    <= bus.iRegDstResult;
      end
   end

   // High address bits drop out, so accesses wrap.
   assign w_idx  = r_em.alu[ADDR_W+1:2];
   assign w_word = r_mem[w_idx];
   assign w_half = r_em.alu[1] ? w_word[31:16] : w_word[15:0];
   assign w_byte = w_word[8*r_em.alu[1:0] +: 8];

   // Lane select and sign/zero extension of the load.
   always_comb begin
      w_ext = w_word;
      unique case (r_em.semux)
         2'b00: w_ext = w_word;
         2'b01: w_ext = {{16{w_half[15]}}, w_half};
         2'b10: w_ext = {{24{w_byte[7]}}, w_byte};
         2'b11: w_ext = {24'd0, w_byte};
         default: w_ext = w_word;
      endcase
   end

   assign w_rdata = r_em.mr ? w_ext : 32'd0;

   // Byte enables and lane-replicated store data.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = r_em.rr2;
      unique case (r_em.mw)
         2'b01: w_be = 4'b1111;
         2'b10: begin
            w_be    = r_em.alu[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_em.rr2[15:0]}};
         end
         2'b11: begin
            w_be    = 4'b0001 << r_em.alu[1:0];
            w_wdata = {4{r_em.rr2[7:0]}};
         end
         default: w_be = 4'b0000;
      endcase
   end

   // Memory keeps contents across reset; reset only blocks the write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   // MEM/WB register; load data sampled before this edge's write.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_wb <= '0;
      end else begin
         r_wb.rw    <= r_em.rw;
         r_wb.sad   <= r_em.sad;
         r_wb.move  <= r_em.move;
         r_wb.hlw   <= r_em.hlw;
         r_wb.m2r   <= r_em.m2r;
         r_wb.rdata <= w_rdata;
         r_wb.alu   <= r_em.alu;
         r_wb.pc4   <= r_em.pc4;
         r_wb.hi    <= r_em.hi;
         r_wb.lo    <= r_em.lo;
         r_wb.hilo  <= r_em.hilo;
         r_wb.rd    <= r_em.rd;
      end
   end

   assign bus.MEMrd          = r_em.rd;
   assign bus.MEMRegWrite    = r_em.rw;
   assign bus.MEMForwardData = r_em.alu;

   assign bus.oRegWriteCtrl  = r_wb.rw;
   assign bus.oSAD           = r_wb.sad;
   assign bus.oMove          = r_wb.move;
   assign bus.oHiLoWrite     = r_wb.hlw;
   assign bus.oMemToReg      = r_wb.m2r;
   assign bus.oMemReadData   = r_wb.rdata;
   assign bus.oALUResult     = r_wb.alu;
   assign bus.oPCPlus4       = r_wb.pc4;
   assign bus.oHi            = r_wb.hi;
   assign bus.oLo            = r_wb.lo;
   assign bus.oHiLoResult    = r_wb.hilo;
   assign bus.oRegDstResult  = r_wb.rd;
endmodule

// File: tb/tb_mem_stage_c.sv
// Scoreboard bench for mem_stage_c: directed vectors,
// expected records queued by the driver, popped by a monitor.
`timescale 1ns/100ps
module tb_mem_stage_c;
   logic Clk = 1'b0;
   logic Reset = 1'b0;
   always #5 Clk = ~Clk;

   mem_stage_c_if bus();

   mem_stage_c #(.ADDR_W(10), .INIT_FILE("")) dut (
      .Clk(Clk),
      .Reset(Reset),
      .bus(bus.slave)
   );

   typedef struct {
      bit          bub;
      logic        sad, rw, move, mr, hlw;
      logic [1:0]  sem, mw;
      logic [2:0]  m2r;
      logic [31:0] pc4, alu, rr2, hi, lo;
      logic [63:0] hilo;
      logic [4:0]  rd;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t q[$];
   vec_t prev, mcur;
   bit   have_prev = 0;
   bit   mon_en = 0;
   int   ncmp = 0, nerr = 0, npush = 0, npop = 0, seq = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic vec_t op(input logic rw, input logic [4:0] rd,
                               input logic [31:0] alu,
                               input logic [1:0] mw,
                               input logic [31:0] rr2, input logic mr,
                               input logic [1:0] sem,
                               input logic [31:0] exp);
      vec_t v = '{default: 0};
      v.rw = rw; v.rd = rd; v.alu = alu; v.mw = mw; v.rr2 = rr2;
      v.mr = mr; v.sem = sem; v.exp_rdata = exp;
      return v;
   endfunction

   function automatic vec_t bub();
      vec_t v = '{default: 0};
      v.bub = 1'b1;
      return v;
   endfunction

   task automatic issue(input vec_t vin, input bit push);
      vec_t v = vin;
      if (!v.bub) begin
         seq++;
         v.pc4  = 32'h0040_0000 + seq * 4;
         v.hi   = 32'h1111_0000 + seq;
         v.lo   = 32'h2222_0000 + seq;
         v.hilo = {v.hi, v.lo} ^ 64'hF0F0_0F0F_00FF_FF00;
         v.m2r  = seq[2:0];
         v.sad  = seq[0];
         v.move = seq[1];
         v.hlw  = seq[2];
      end
      bus.iSAD = v.sad; bus.iRegWriteCtrl = v.rw; bus.iMove = v.move;
      bus.iMemRead = v.mr; bus.iHiLoWrite = v.hlw;
      bus.iSEMux = v.sem; bus.iMemWrite = v.mw; bus.iMemToReg = v.m2r;
      bus.iPCPlus4 = v.pc4; bus.iALUResult = v.alu;
      bus.iReadReg2 = v.rr2; bus.iHi = v.hi; bus.iLo = v.lo;
      bus.iHiLoResult = v.hilo; bus.iRegDstResult = v.rd;
      bus.iZero = 1'($urandom);
      bus.iReadReg1 = $urandom;
      if (push) begin
         q.push_back(v);
         npush++;
      end
      @(negedge Clk);
   endtask

   task automatic rnd_inputs();
      bus.iSAD = 1'($urandom); bus.iRegWriteCtrl = 1'($urandom);
      bus.iMove = 1'($urandom); bus.iMemRead = 1'($urandom);
      bus.iZero = 1'($urandom); bus.iHiLoWrite = 1'($urandom);
      bus.iSEMux = 2'($urandom); bus.iMemWrite = 2'($urandom);
      bus.iMemToReg = 3'($urandom);
      bus.iPCPlus4 = $urandom; bus.iALUResult = $urandom;
      bus.iReadReg1 = $urandom; bus.iReadReg2 = $urandom;
      bus.iHi = $urandom; bus.iLo = $urandom;
      bus.iHiLoResult = {$urandom, $urandom};
      bus.iRegDstResult = 5'($urandom);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem"},
          {bus.MEMrd, bus.MEMRegWrite, bus.MEMForwardData}, 64'd0);
      chk({tag, "_ctl"},
          {bus.oRegWriteCtrl, bus.oSAD, bus.oMove, bus.oHiLoWrite,
           bus.oMemToReg, bus.oRegDstResult}, 64'd0);
      chk({tag, "_dat"}, {bus.oMemReadData, bus.oALUResult}, 64'd0);
      chk({tag, "_pchi"}, {bus.oPCPlus4, bus.oHi}, 64'd0);
      chk({tag, "_lo"}, bus.oLo, 64'd0);
      chk({tag, "_hilo"}, bus.oHiLoResult, 64'd0);
   endtask

   // Monitor: MEM taps vs newest record, WB outputs vs previous.
   always begin
      @(posedge Clk);
      #1;
      if (mon_en) begin
         if (have_prev) begin
            chk("wb_rw", bus.oRegWriteCtrl, prev.rw);
            chk("wb_sad", bus.oSAD, prev.sad);
            chk("wb_move", bus.oMove, prev.move);
            chk("wb_hlw", bus.oHiLoWrite, prev.hlw);
            chk("wb_m2r", bus.oMemToReg, prev.m2r);
            chk("wb_rdata", bus.oMemReadData, prev.exp_rdata);
            chk("wb_alu", bus.oALUResult, prev.alu);
            chk("wb_pc4", bus.oPCPlus4, prev.pc4);
            chk("wb_hi", bus.oHi, prev.hi);
            chk("wb_lo", bus.oLo, prev.lo);
            chk("wb_hilo", bus.oHiLoResult, prev.hilo);
            chk("wb_rd", bus.oRegDstResult, prev.rd);
         end
         if (q.size() > 0) begin
            mcur = q.pop_front();
            npop++;
            chk("mem_rd", bus.MEMrd, mcur.rd);
            chk("mem_rw", bus.MEMRegWrite, mcur.rw);
            chk("mem_fwd", bus.MEMForwardData, mcur.alu);
            prev = mcur;
            have_prev = 1;
         end else begin
            have_prev = 0;
         end
      end else begin
         have_prev = 0;
      end
   end

   initial begin
      int t;
      Reset = 1'b0;
      repeat (3) begin
         @(negedge Clk);
         rnd_inputs();
         #2;
         chk_zero("rst");
      end
      @(negedge Clk);
      Reset = 1'b1;
      mon_en = 1;

      issue(op(1, 5'd3, 32'h1234, 2'b00, 0, 0, 2'b00, 0), 1);
      issue(op(0, 5'd0, 32'h10, 2'b01, 32'hDEADBEEF, 0, 2'b00, 0), 1);
      issue(op(1, 5'd4, 32'h10, 2'b00, 0, 1, 2'b00, 32'hDEADBEEF), 1);
      issue(op(0, 5'd0, 32'h13, 2'b11, 32'hCAFE0055, 0, 2'b00, 0), 1);
      issue(op(1, 5'd5, 32'h10, 2'b00, 0, 1, 2'b00, 32'h55ADBEEF), 1);
      issue(op(0, 5'd0, 32'h10, 2'b10, 32'hABCD1234, 0, 2'b00, 0), 1);
      issue(op(1, 5'd6, 32'h10, 2'b00, 0, 1, 2'b00, 32'h55AD1234), 1);
      issue(op(0, 5'd0, 32'h20, 2'b01, 32'h80FF7F01, 0, 2'b00, 0), 1);
      issue(op(1, 5'd7, 32'h22, 2'b00, 0, 1, 2'b01, 32'hFFFF80FF), 1);
      issue(op(1, 5'd7, 32'h23, 2'b00, 0, 1, 2'b01, 32'hFFFF80FF), 1);
      issue(op(1, 5'd8, 32'h22, 2'b00, 0, 1, 2'b10, 32'hFFFFFFFF), 1);
      issue(op(1, 5'd8, 32'h21, 2'b00, 0, 1, 2'b11, 32'h0000007F), 1);
      issue(op(1, 5'd8, 32'h20, 2'b00, 0, 1, 2'b10, 32'h00000001), 1);
      issue(op(1, 5'd9, 32'h40, 2'b00, 0, 0, 2'b00, 0), 1);
      issue(bub(), 1);
      issue(op(1, 5'd10, 32'h20, 2'b00, 0, 1, 2'b00, 32'h80FF7F01), 1);
      issue(op(0, 5'd0, 32'h1004, 2'b01, 32'hA5A5A5A5, 0, 2'b00, 0), 1);
      issue(op(1, 5'd11, 32'h4, 2'b00, 0, 1, 2'b00, 32'hA5A5A5A5), 1);
      issue(op(1, 5'd11, 32'h1010, 2'b00, 0, 1, 2'b00, 32'h55AD1234), 1);
      issue(op(1, 5'd12, 32'h10, 2'b00, 0, 0, 2'b00, 0), 1);
      issue(op(0, 5'd0, 32'h30, 2'b01, 32'h22222222, 0, 2'b00, 0), 1);
      issue(op(1, 5'd12, 32'h30, 2'b00, 0, 1, 2'b00, 32'h22222222), 1);
      issue(bub(), 1);

      issue(op(0, 5'd5, 32'h30, 2'b01, 32'h11111111, 0, 2'b00, 0), 0);
      mon_en = 0;
      #3;
      chk("pre_rst_fwd", bus.MEMForwardData, 32'h30);
      #1;
      Reset = 1'b0;
      #0.5;
      chk("mid_rst_fwd", bus.MEMForwardData, 0);
      chk("mid_rst_rd", bus.MEMrd, 0);
      @(negedge Clk);
      @(negedge Clk);
      chk_zero("mid_rst");
      bus.iMemWrite = 2'b00;
      bus.iRegWriteCtrl = 1'b0;
      Reset = 1'b1;
      mon_en = 1;
      issue(op(1, 5'd13, 32'h30, 2'b00, 0, 1, 2'b00, 32'h22222222), 1);
      issue(bub(), 1);
      issue(bub(), 1);

      t = 0;
      while (q.size() > 0 && t < 20) begin
         @(negedge Clk);
         t++;
      end
      @(negedge Clk);
      mon_en = 0;
      chk("drain", npop, npush);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               ncmp, nerr);
      $finish;
   end
endmodule
